// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: raster sequencer for a DVI/TMDS generator, single clock domain (clk_pix).
//
// Walks an H_TOTAL x V_TOTAL raster. During active video it pulls pixels from an upstream
// valid/ready source. It presents them one cycle later on data_ch*, aligned with de,
// sx/sy, ctrl_ch0 and the start pulses. Frames always run to completion: dropping en
// mid-frame finishes the current frame before the block returns to idle.
//
// Ports:
//   clk_pix        pixel clock
//   rst            synchronous active-high reset
//   en             run request
//   pix_valid      upstream pixel valid
//   pix_data       {ch2, ch1, ch0} pixel bytes
//   pix_ready      pixel accepted this cycle (combinational from state/position)
//   de             data enable to the generator
//   data_ch0..2    pixel bytes to the generator
//   ctrl_ch0       {vsync, hsync}
//   ctrl_ch1..2    constant 2'b00
//   sx, sy         registered raster position
//   frame_start    one-cycle pulse at (0,0)
//   line_start     one-cycle pulse at sx==0
//   busy           sequencer not idle
//   underflow      active pixel had no valid data
//   underflow_cnt  saturating underflow count, cleared only by rst
module dvi_timing_ctrl #(
  parameter int unsigned CORDW  = 16,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             en,
  input  logic             pix_valid,
  input  logic [23:0]      pix_data,
  output logic             pix_ready,
  output logic             de,
  output logic [7:0]       data_ch0,
  output logic [7:0]       data_ch1,
  output logic [7:0]       data_ch2,
  output logic [1:0]       ctrl_ch0,
  output logic [1:0]       ctrl_ch1,
  output logic [1:0]       ctrl_ch2,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             frame_start,
  output logic             line_start,
  output logic             busy,
  output logic             underflow,
  output logic [15:0]      underflow_cnt
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] HLast      = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] VLast      = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] HAct       = CORDW'(H_RES);
  localparam logic [CORDW-1:0] VAct       = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HSyncStart = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HSyncStop  = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VSyncStart = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VSyncStop  = CORDW'(V_RES + V_FP + V_SYNC);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           state_q, state_d;
  logic [CORDW-1:0] h_q, h_d;
  logic [CORDW-1:0] v_q, v_d;

  logic             de_d;
  logic [23:0]      data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CORDW-1:0] sx_q, sy_q;
  logic             frame_start_d, line_start_d;
  logic             busy_d;
  logic             underflow_d;
  logic [15:0]      cnt_q, cnt_d;

  logic running, active, line_last, frame_last, hsync_on, vsync_on, take, starve;

  always_comb begin
    running    = (state_q != StIdle);
    active     = (h_q < HAct) && (v_q < VAct);
    line_last  = (h_q == HLast);
    frame_last = line_last && (v_q == VLast);
    hsync_on   = (h_q >= HSyncStart) && (h_q < HSyncStop);
    vsync_on   = (v_q >= VSyncStart) && (v_q < VSyncStop);
    take       = running && active && pix_valid;
    starve     = running && active && !pix_valid;
  end

  assign pix_ready = running && active;

  // Next state and raster position. Only the last position of a frame may enter idle,
  // so the counters are already back at (0,0) whenever the sequencer is idle.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun:  if (!en) state_d = frame_last ? StIdle : StStop;
      StStop: begin
        if (en)              state_d = StRun;
        else if (frame_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (running) begin
      if (line_last) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + CORDW'(1);
      end else begin
        h_d = h_q + CORDW'(1);
      end
    end
  end

  // Registered outputs: everything below describes the current cycle and appears next cycle.
  always_comb begin
    de_d          = running && active;
    data_d        = take ? pix_data : 24'h0;
    ctrl_d        = {~V_POL, ~H_POL};
    if (running) begin
      ctrl_d = {vsync_on ? V_POL : ~V_POL, hsync_on ? H_POL : ~H_POL};
    end
    frame_start_d = running && (h_q == '0) && (v_q == '0);
    line_start_d  = running && (h_q == '0);
    busy_d        = running;
    underflow_d   = starve;
    cnt_d         = cnt_q;
    if (starve && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      de          <= 1'b0;
      data_q      <= 24'h0;
      ctrl_q      <= {~V_POL, ~H_POL};
      sx_q        <= '0;
      sy_q        <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      busy        <= 1'b0;
      underflow   <= 1'b0;
      cnt_q       <= 16'h0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      de          <= de_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      sx_q        <= h_q;
      sy_q        <= v_q;
      frame_start <= frame_start_d;
      line_start  <= line_start_d;
      busy        <= busy_d;
      underflow   <= underflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign data_ch0      = data_q[7:0];
  assign data_ch1      = data_q[15:8];
  assign data_ch2      = data_q[23:16];
  assign ctrl_ch0      = ctrl_q;
  assign ctrl_ch1      = 2'b00;
  assign ctrl_ch2      = 2'b00;
  assign sx            = sx_q;
  assign sy            = sy_q;
  assign underflow_cnt = cnt_q;

endmodule
